// File: rtl/mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU load/store
// unit and the key/ciphertext loader) and the synchronous data RAM.
// The slave view is the arbiter; the master view is the surrounding environment.
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    // CPU load/store port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    // External loader port
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    // Synchronous RAM port (one-cycle read latency)
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported synchronous data RAM.
// The FSM state names the bus owner for the current cycle. A requester granted
// this cycle is not eligible at the coming edge, so back-to-back requests from
// both sides alternate with no idle cycle. The CPU wins ties unless the loader
// has been kept waiting for STARVE cycles. Reads return one cycle after the
// grant on the port that owned the bus.
module mem_arbiter #(
    parameter int AW     = 10,
    parameter int DW     = 32,
    parameter int STARVE = 4
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    // Wide enough to hold 0..STARVE, and never zero-width.
    localparam int            CW         = $clog2(STARVE + 2);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        EXT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // Arbitration is held off for the first edge after reset release so the
    // earliest grant decision happens at the second rising edge.
    logic          ready;

    logic          cpu_elig;
    logic          ext_elig;
    logic [CW-1:0] starve_cnt;

    // Registered RAM command (issued in the cycle named by state)
    logic          en_p0;
    logic          we_p0;
    logic [AW-1:0] addr_p0;
    logic [DW-1:0] wdata_p0;

    // Read-return valid, one cycle behind the issuing grant
    logic          vld_cpu_p1;
    logic          vld_ext_p1;

    // Saturating increment of the loader wait counter.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == STARVE_MAX) begin
            return v;
        end
        return v + CW'(1);
    endfunction

    // Pick the next bus owner from the eligible requests.
    always_comb begin
        state_next = IDLE;
        cpu_elig   = ready && bus.cpu_req && (state != CPU);
        ext_elig   = ready && bus.ext_req && (state != EXT);
        if (cpu_elig && ext_elig) begin
            state_next = (starve_cnt == STARVE_MAX) ? EXT : CPU;
        end else if (cpu_elig) begin
            state_next = CPU;
        end else if (ext_elig) begin
            state_next = EXT;
        end
    end

    // Owner register and post-reset arbitration enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ready <= 1'b0;
        end else begin
            state <= state_next;
            ready <= 1'b1;
        end
    end

    // ---- stage p0: latch the winner's command toward the RAM ----
    // Capture the winning requester's command at the deciding edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_p0    <= 1'b0;
            we_p0    <= 1'b0;
            addr_p0  <= '0;
            wdata_p0 <= '0;
        end else begin
            unique case (state_next)
                CPU: begin
                    en_p0    <= 1'b1;
                    we_p0    <= bus.cpu_we;
                    addr_p0  <= bus.cpu_addr;
                    wdata_p0 <= bus.cpu_wdata;
                end
                EXT: begin
                    en_p0    <= 1'b1;
                    we_p0    <= bus.ext_we;
                    addr_p0  <= bus.ext_addr;
                    wdata_p0 <= bus.ext_wdata;
                end
                default: begin
                    en_p0    <= 1'b0;
                    we_p0    <= 1'b0;
                    addr_p0  <= '0;
                    wdata_p0 <= '0;
                end
            endcase
        end
    end

    // ---- stage p1: RAM read data returns to the previous owner ----
    // Remember which port issued a read so its data can be steered back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_cpu_p1 <= 1'b0;
            vld_ext_p1 <= 1'b0;
        end else begin
            vld_cpu_p1 <= (state == CPU) && !we_p0;
            vld_ext_p1 <= (state == EXT) && !we_p0;
        end
    end

    // Count how long the loader has been waiting; any grant or drop clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (bus.ext_req && (state != EXT)) begin
            starve_cnt <= sat_inc(starve_cnt);
        end else begin
            starve_cnt <= '0;
        end
    end

    assign bus.cpu_gnt    = (state == CPU);
    assign bus.ext_gnt    = (state == EXT);
    assign bus.cpu_stall  = bus.cpu_req && (state != CPU);

    assign bus.mem_en     = en_p0;
    assign bus.mem_we     = we_p0;
    assign bus.mem_addr   = addr_p0;
    assign bus.mem_wdata  = wdata_p0;

    assign bus.cpu_rvalid = vld_cpu_p1;
    assign bus.ext_rvalid = vld_ext_p1;
    assign bus.cpu_rdata  = vld_cpu_p1 ? bus.mem_rdata : '0;
    assign bus.ext_rdata  = vld_ext_p1 ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a synchronous RAM model, a cycle-level reference model
// of the arbitration rules with its own shadow memory, a per-cycle compare
// process, and directed scenarios with literal expected values.
module tb_mem_arbiter;
    localparam int AW     = 10;
    localparam int DW     = 32;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM, one-cycle read latency; contents start as 0x1000_0000+addr.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    assign bus.mem_rdata = ram_q;
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h1000_0000 + i;
        ram[5] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (bus.mem_en) begin
                if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
                else            ram_q <= ram[bus.mem_addr];
            end
        end
    end

    // Reference model: owner 0=none, 1=cpu, 2=ext.
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    int            m_own     = 0;
    bit            m_we      = 0;
    logic [AW-1:0] m_addr    = '0;
    logic [DW-1:0] m_wdata   = '0;
    bit            m_rvc     = 0;
    bit            m_rve     = 0;
    logic [DW-1:0] m_rdata_c = '0;
    logic [DW-1:0] m_rdata_e = '0;
    int            m_cnt     = 0;
    bit            m_ready   = 0;
    int            m_win;
    bit            m_ec, m_ee;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = 32'h1000_0000 + i;
        mdl_mem[5] = 32'hDEAD_BEEF;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_rvc = 0; m_rve = 0; m_cnt = 0; m_ready = 0;
        end else begin
            // finish the access that occupied the ending cycle
            m_rvc = 0;
            m_rve = 0;
            if (m_own != 0) begin
                if (m_we) mdl_mem[m_addr] = m_wdata;
                else if (m_own == 1) begin m_rvc = 1; m_rdata_c = mdl_mem[m_addr]; end
                else begin m_rve = 1; m_rdata_e = mdl_mem[m_addr]; end
            end
            // decide the next owner
            m_ec = m_ready && bus.cpu_req && (m_own != 1);
            m_ee = m_ready && bus.ext_req && (m_own != 2);
            if (m_ec && m_ee) m_win = (m_cnt == STARVE) ? 2 : 1;
            else if (m_ec)    m_win = 1;
            else if (m_ee)    m_win = 2;
            else              m_win = 0;
            if (bus.ext_req && (m_own != 2)) m_cnt = (m_cnt < STARVE) ? m_cnt + 1 : STARVE;
            else                             m_cnt = 0;
            m_ready = 1;
            m_own   = m_win;
            if (m_win == 1) begin
                m_we = bus.cpu_we; m_addr = bus.cpu_addr; m_wdata = bus.cpu_wdata;
            end else if (m_win == 2) begin
                m_we = bus.ext_we; m_addr = bus.ext_addr; m_wdata = bus.ext_wdata;
            end else begin
                m_we = 0; m_addr = '0; m_wdata = '0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            check("cpu_gnt",    bus.cpu_gnt,    m_own == 1);
            check("ext_gnt",    bus.ext_gnt,    m_own == 2);
            check("mem_en",     bus.mem_en,     m_own != 0);
            check("mem_we",     bus.mem_we,     m_we);
            if (m_own != 0) begin
                check("mem_addr",  bus.mem_addr,  m_addr);
                check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check("cpu_stall",  bus.cpu_stall,  bus.cpu_req && (m_own != 1));
            check("cpu_rvalid", bus.cpu_rvalid, m_rvc);
            check("ext_rvalid", bus.ext_rvalid, m_rve);
            check("cpu_rdata",  bus.cpu_rdata,  m_rvc ? m_rdata_c : '0);
            check("ext_rdata",  bus.ext_rdata,  m_rve ? m_rdata_e : '0);
            check("starve_cnt", dut.starve_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 0; bus.ext_we = 0; bus.ext_addr = '0; bus.ext_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"},     bus.mem_en,     0);
        check({tag, "_mem_we"},     bus.mem_we,     0);
        check({tag, "_mem_addr"},   bus.mem_addr,   0);
        check({tag, "_mem_wdata"},  bus.mem_wdata,  0);
        check({tag, "_cpu_gnt"},    bus.cpu_gnt,    0);
        check({tag, "_ext_gnt"},    bus.ext_gnt,    0);
        check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        check({tag, "_ext_rvalid"}, bus.ext_rvalid, 0);
        check({tag, "_cpu_rdata"},  bus.cpu_rdata,  0);
        check({tag, "_starve"},     dut.starve_cnt, 0);
    endtask

    int g;

    initial begin
        idle_reqs();
        rst = 0;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #3 rst = 1;
        tick();
        tick();

        // Lone CPU read of address 5
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h005;
        @(negedge clk);
        check("t1_stall_c0", bus.cpu_stall, 1);
        check("t1_gnt_c0",   bus.cpu_gnt,   0);
        tick();
        @(negedge clk);
        check("t1_gnt_c1",   bus.cpu_gnt,   1);
        check("t1_addr_c1",  bus.mem_addr,  10'h005);
        check("t1_stall_c1", bus.cpu_stall, 0);
        tick();
        bus.cpu_req = 0;
        @(negedge clk);
        check("t1_rvalid_c2", bus.cpu_rvalid, 1);
        check("t1_rdata_c2",  bus.cpu_rdata,  32'hDEAD_BEEF);
        tick();
        tick();

        // Simultaneous CPU and EXT reads
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h010;
        bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 10'h020;
        tick();
        @(negedge clk);
        check("t2_cgnt_c1", bus.cpu_gnt, 1);
        check("t2_egnt_c1", bus.ext_gnt, 0);
        tick();
        bus.cpu_req = 0;
        @(negedge clk);
        check("t2_egnt_c2",   bus.ext_gnt,    1);
        check("t2_crv_c2",    bus.cpu_rvalid, 1);
        check("t2_crdata_c2", bus.cpu_rdata,  32'h1000_0010);
        tick();
        bus.ext_req = 0;
        @(negedge clk);
        check("t2_erv_c3",    bus.ext_rvalid, 1);
        check("t2_erdata_c3", bus.ext_rdata,  32'h1000_0020);
        check("t2_crv_c3",    bus.cpu_rvalid, 0);
        tick();
        tick();

        // EXT request withdrawn while the CPU holds the bus
        bus.cpu_req = 1; bus.cpu_addr = 10'h030;
        bus.ext_req = 1; bus.ext_addr = 10'h031;
        tick();
        bus.cpu_req = 0;
        bus.ext_req = 0;
        tick();
        @(negedge clk);
        check("t3_en_c2",    bus.mem_en,    0);
        check("t3_egnt_c2",  bus.ext_gnt,   0);
        check("t3_rdata_c2", bus.cpu_rdata, 32'h1000_0030);
        tick();
        @(negedge clk);
        check("t3_erv_c3", bus.ext_rvalid, 0);
        tick();

        // CPU requesting continuously while EXT waits
        g = -1;
        for (int c = 0; c < STARVE + 4; c++) begin
            bus.cpu_req  = 1;
            bus.cpu_we   = 0;
            bus.cpu_addr = AW'(64 + c);
            if (c == 1) begin
                bus.ext_req = 1; bus.ext_we = 0; bus.ext_addr = 10'h041;
            end
            if (g >= 0 && c == g + 1) bus.ext_req = 0;
            @(negedge clk);
            if (bus.ext_gnt && g < 0) g = c;
            tick();
        end
        check("t4_ext_granted", g >= 0, 1);
        check("t4_within_bound", (g >= 0) && (g - 1 <= STARVE + 1), 1);
        check("t4_gnt_cycle", g, 2);
        bus.cpu_req = 0;
        @(negedge clk);
        check("t4_starve_zero", dut.starve_cnt, 0);
        tick();
        tick();

        // EXT write at 0x3FF followed by CPU read-back
        bus.ext_req = 1; bus.ext_we = 1; bus.ext_addr = 10'h3FF; bus.ext_wdata = 32'h1234_5678;
        @(negedge clk);
        check("t5_egnt_c0", bus.ext_gnt, 0);
        tick();
        @(negedge clk);
        check("t5_egnt_c1",  bus.ext_gnt,   1);
        check("t5_we_c1",    bus.mem_we,    1);
        check("t5_addr_c1",  bus.mem_addr,  10'h3FF);
        check("t5_wdata_c1", bus.mem_wdata, 32'h1234_5678);
        tick();
        bus.ext_req = 0; bus.ext_we = 0;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h3FF;
        @(negedge clk);
        check("t5_we_c2",  bus.mem_we,     0);
        check("t5_erv_c2", bus.ext_rvalid, 0);
        tick();
        @(negedge clk);
        check("t5_cgnt_c3", bus.cpu_gnt, 1);
        check("t5_we_c3",   bus.mem_we,  0);
        tick();
        bus.cpu_req = 0;
        @(negedge clk);
        check("t5_crv_c4",    bus.cpu_rvalid, 1);
        check("t5_crdata_c4", bus.cpu_rdata,  32'h1234_5678);
        check("t5_erv_c4",    bus.ext_rvalid, 0);
        tick();
        tick();

        // Reset asserted during a granted CPU read
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h005;
        tick();
        #1;
        check("t6_gnt_before", bus.cpu_gnt, 1);
        rst = 0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk);
        #3 rst = 1;
        @(negedge clk);
        check("t6_rv_a",  bus.cpu_rvalid, 0);
        check("t6_gnt_a", bus.cpu_gnt,    0);
        tick();
        @(negedge clk);
        check("t6_rv_b",  bus.cpu_rvalid, 0);
        check("t6_gnt_b", bus.cpu_gnt,    0);
        tick();
        @(negedge clk);
        check("t6_gnt_c",  bus.cpu_gnt,  1);
        check("t6_addr_c", bus.mem_addr, 10'h005);
        tick();
        bus.cpu_req = 0;
        @(negedge clk);
        check("t6_rv_d",    bus.cpu_rvalid, 1);
        check("t6_rdata_d", bus.cpu_rdata,  32'hDEAD_BEEF);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, data-memory word-address width.
REQ-002 SHALL have parameter DW, default 32, data word width.
REQ-003 SHALL have parameter STARVE, default 4, maximum cycles the external port waits before it gains priority.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cpu_req  input  1  CPU LDR/STR access request, held until cpu_gnt.
REQ-007 SHALL have port cpu_we  input  1  CPU write enable (STR=1, LDR=0), from WM_En.
REQ-008 SHALL have port cpu_addr  input  AW  CPU word address.
REQ-009 SHALL have port cpu_wdata  input  DW  CPU store data.
REQ-010 SHALL have port cpu_gnt  output  1  one-cycle pulse: CPU access issued to memory this cycle.
REQ-011 SHALL have port cpu_rvalid  output  1  one-cycle pulse: cpu_rdata valid.
REQ-012 SHALL have port cpu_rdata  output  DW  CPU read data.
REQ-013 SHALL have port cpu_stall  output  1  pipeline stall, cpu_req AND NOT cpu_gnt.
REQ-014 SHALL have ports ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rvalid, ext_rdata with the same directions, widths and meanings as the CPU ports, for the key/ciphertext loader.
REQ-015 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, AW), mem_wdata (output, DW) and mem_rdata (input, DW) for a synchronous RAM with one-cycle read latency.

Function
REQ-016 SHALL implement FSM states IDLE, CPU, EXT; state names the owner of the memory bus in the current cycle.
REQ-017 SHALL arbitrate at every rising edge among asserted requests, excluding the requester granted in the current cycle.
REQ-018 SHALL give the CPU priority when both requests are eligible, unless starve_cnt equals STARVE; in that case EXT wins.
REQ-019 SHALL transition: any state -> CPU when CPU wins; -> EXT when EXT wins; -> IDLE when no eligible request.
REQ-020 SHALL register all memory outputs: in CPU/EXT, mem_en=1 and mem_we/mem_addr/mem_wdata equal the winner's inputs sampled at the deciding edge; in IDLE, mem_en=0 and mem_we=0.
REQ-021 SHALL assert cpu_gnt exactly in CPU-state cycles and ext_gnt exactly in EXT-state cycles, never both at once.
REQ-022 SHALL set minimum latency request-to-grant to 1 cycle and grant-to-rvalid to 1 cycle, for reads only.
REQ-023 SHALL pulse the rvalid of the previous owner the cycle after a read grant, with mem_rdata routed combinationally to that port's rdata; writes produce no rvalid.
REQ-024 SHALL allow back-to-back alternating grants (CPU, EXT, CPU, ...) with no idle cycle; the same requester is granted at most every other cycle.
REQ-025 SHALL increment starve_cnt, saturating at STARVE, each cycle ext_req=1 and ext_gnt=0; clear it to 0 on ext_gnt or when ext_req=0.
REQ-026 SHALL drive unselected rdata outputs to 0.
REQ-027 SHALL treat a request dropped before grant as withdrawn, with no access and no error.

Reset
REQ-028 SHALL, on rst=0 at any time, immediately enter IDLE and force mem_en, mem_we, cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid=0, mem_addr and mem_wdata=0, and starve_cnt=0.
REQ-029 SHALL discard any in-flight read on reset, with no rvalid after release.
REQ-030 SHALL make the first grant possible at the second rising edge after rst deasserts with a request held.

Verification
REQ-031 SHALL cover: CPU LDR addr 0x005 alone, RAM[5]=0xDEADBEEF -> cpu_gnt at cycle 1, cpu_rvalid with cpu_rdata=0xDEADBEEF at cycle 2, cpu_stall=1 in cycle 0 only.
REQ-032 SHALL cover: CPU and EXT request in the same cycle, both reads -> CPU granted, EXT granted the next cycle, rvalids in consecutive cycles with correct data.
REQ-033 SHALL cover: CPU holds requests continuously, re-raising immediately after each grant, while EXT waits -> EXT granted no later than STARVE+1 cycles after ext_req rises; starve_cnt then returns to 0.
REQ-034 SHALL cover: EXT STR 0x12345678 to addr 0x3FF (wrap-edge address), then CPU LDR 0x3FF -> mem_we=1 for one cycle, no ext_rvalid, cpu_rdata=0x12345678.
REQ-035 SHALL cover: rst=0 asserted while a CPU read is granted -> all outputs 0 asynchronously, no cpu_rvalid after release, and the request is re-granted correctly once rst=1.
